// File: rtl/lsu_port_if.sv
// lsu_port_if: the signal bundle between the core, the load/store port and
// the byte-banked data memory.
//
// Core request side:  I_valid, I_we, I_funct3, I_addr, I_wdata
// Core result side:   O_busy, O_done, O_err, O_rdata
// Memory side:        O_maddr, O_mdata, O_mmask, O_mwe (to memory)
//                     I_mdata, I_mstall (from memory)
// Debug:              dbg_state (current FSM state of the port)
//
// Handshake: the core raises I_valid with a stable request. The port samples
// it only while idle (O_busy = 0) and ignores it while busy. Completion is a
// single-cycle O_done, qualified by O_err. On the memory side an access is
// presented while the port is in its issue state. It is taken on the first
// clock edge with I_mstall = 0, and read data returns one cycle later.
//
// slave modport:  the lsu_port itself.
// master modport: the core/memory environment that drives it.
interface lsu_port_if;
  logic        I_valid;
  logic        I_we;
  logic [2:0]  I_funct3;
  logic [31:0] I_addr;
  logic [31:0] I_wdata;
  logic        O_busy;
  logic        O_done;
  logic        O_err;
  logic [31:0] O_rdata;
  logic [31:0] O_maddr;
  logic [31:0] O_mdata;
  logic [3:0]  O_mmask;
  logic        O_mwe;
  logic [31:0] I_mdata;
  logic        I_mstall;
  logic [1:0]  dbg_state;

  modport slave (
    input  I_valid, I_we, I_funct3, I_addr, I_wdata, I_mdata, I_mstall,
    output O_busy, O_done, O_err, O_rdata,
    output O_maddr, O_mdata, O_mmask, O_mwe, dbg_state
  );

  modport master (
    output I_valid, I_we, I_funct3, I_addr, I_wdata, I_mdata, I_mstall,
    input  O_busy, O_done, O_err, O_rdata,
    input  O_maddr, O_mdata, O_mmask, O_mwe, dbg_state
  );
endinterface

// File: rtl/lsu_port.sv
// lsu_port: load/store initiator between the execute stage and the
// byte-banked data memory.
//
// Ports:
//   I_clk  - clock, rising edge
//   I_rst  - synchronous, active-high reset
//   bus    - lsu_port_if.slave: core request/result and memory port signals
//
// Flow per request: IDLE -> ISSUE (held while I_mstall) -> WAIT -> IDLE.
// An illegal funct3 goes IDLE -> ERR -> IDLE with no memory access.
// O_done/O_err are registered on the edge leaving WAIT/ERR, so the done
// cycle is already an IDLE cycle that can accept the next request.
//
// The memory returns read data in bank order {b3,b2,b1,b0}. The byte at the
// requested address sits in bank addr[1:0], so a right rotation by
// 8*addr[1:0] brings it to bit 0. Store data goes out unmodified, and the
// memory rotates it into its lanes.
module lsu_port (
  input logic      I_clk,
  input logic      I_rst,
  lsu_port_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        done_q;
  logic        err_q;

  logic        req_legal;
  logic [31:0] rot;
  logic [31:0] load_val;

  // Legal encodings: stores SB/SH/SW, loads LB/LH/LW/LBU/LHU.
  always_comb begin
    req_legal = 1'b0;
    if (bus.I_we) begin
      req_legal = (bus.I_funct3 == 3'd0) || (bus.I_funct3 == 3'd1) ||
                  (bus.I_funct3 == 3'd2);
    end else begin
      req_legal = (bus.I_funct3 == 3'd0) || (bus.I_funct3 == 3'd1) ||
                  (bus.I_funct3 == 3'd2) || (bus.I_funct3 == 3'd4) ||
                  (bus.I_funct3 == 3'd5);
    end
  end

  // State register
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.I_valid) begin
          state_nxt = req_legal ? S_ISSUE : S_ERR;
        end
      end
      S_ISSUE: begin
        if (!bus.I_mstall) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Undo the bank ordering, then extend per funct3.
  always_comb begin
    rot = bus.I_mdata;
    case (addr_q[1:0])
      2'd0: rot = bus.I_mdata;
      2'd1: rot = {bus.I_mdata[7:0],  bus.I_mdata[31:8]};
      2'd2: rot = {bus.I_mdata[15:0], bus.I_mdata[31:16]};
      2'd3: rot = {bus.I_mdata[23:0], bus.I_mdata[31:24]};
      default: rot = bus.I_mdata;
    endcase
  end

  always_comb begin
    load_val = rot;
    case (funct3_q)
      3'd0: load_val = {{24{rot[7]}}, rot[7:0]};
      3'd1: load_val = {{16{rot[15]}}, rot[15:0]};
      3'd2: load_val = rot;
      3'd4: load_val = {24'd0, rot[7:0]};
      3'd5: load_val = {16'd0, rot[15:0]};
      default: load_val = rot;
    endcase
  end

  // Request latch, result capture and the registered completion flags.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= (state == S_WAIT) || (state == S_ERR);
      err_q  <= (state == S_ERR);
      if ((state == S_IDLE) && bus.I_valid) begin
        we_q     <= bus.I_we;
        funct3_q <= bus.I_funct3;
        addr_q   <= bus.I_addr;
        wdata_q  <= bus.I_wdata;
      end
      // Stores complete through WAIT as well but must not touch O_rdata.
      if ((state == S_WAIT) && !we_q) begin
        rdata_q <= load_val;
      end
    end
  end

  // Outputs. O_mwe/O_mmask are also gated by I_rst so that a reset that
  // lands in ISSUE cannot produce a write in the reset cycle.
  always_comb begin
    bus.O_busy    = (state != S_IDLE);
    bus.O_done    = done_q;
    bus.O_err     = err_q;
    bus.O_rdata   = rdata_q;
    bus.O_maddr   = addr_q;
    bus.O_mdata   = wdata_q;
    bus.dbg_state = state;
    bus.O_mwe     = (state == S_ISSUE) && we_q && !bus.I_mstall && !I_rst;
    bus.O_mmask   = 4'b0000;
    if ((state == S_ISSUE) && we_q && !I_rst) begin
      case (funct3_q[1:0])
        2'd0:    bus.O_mmask = 4'b0001;
        2'd1:    bus.O_mmask = 4'b0011;
        2'd2:    bus.O_mmask = 4'b1111;
        default: bus.O_mmask = 4'b0000;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_port.sv
// tb_lsu_port: directed bench for lsu_port with a behavioural byte-banked
// memory, a scoreboard queue of expected {err, rdata} results and a final
// report line.
module tb_lsu_port;

  logic clk;
  logic rst;

  lsu_port_if bus ();

  lsu_port dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not reach its summary");
    $fatal(1, "global timeout");
  end

  // ---------------- memory model ----------------
  // 1 KiB of byte-banked storage. Byte address a lives in bank a[1:0]. Read
  // data is registered and returned in bank order {b3,b2,b1,b0}. Stores put
  // O_mdata byte i at O_maddr + i for every set bit i of O_mmask.
  logic [7:0] mem [0:1023] = '{default: 8'h00};

  function automatic logic [31:0] rd_win(input logic [31:0] a);
    logic [31:0] r;
    logic [31:0] ad;
    r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      ad = a + i;
      r[8*ad[1:0] +: 8] = mem[ad[9:0]];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    logic [31:0] wa;
    if (bus.O_mwe) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.O_mmask[i]) begin
          wa = bus.O_maddr + i;
          mem[wa[9:0]] <= bus.O_mdata[8*i +: 8];
        end
      end
    end
    bus.I_mdata <= rd_win(bus.O_maddr);
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_err"}, {31'd0, bus.O_err}, {31'd0, e[32]});
      check({tag, "_rdata"}, bus.O_rdata, e[31:0]);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge+1 point. Drives the request immediately, so a call
  // made in the previous op's done cycle exercises back-to-back issue.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int stall, input logic exp_err,
                        input logic [31:0] exp_rdata, input logic [3:0] exp_mask,
                        input int exp_lat);
    int done_at;
    int mwe_cnt;
    int mwe_at;
    exp_q.push_back({exp_err, exp_rdata});
    bus.I_valid  = 1'b1;
    bus.I_we     = we;
    bus.I_funct3 = f3;
    bus.I_addr   = addr;
    bus.I_wdata  = wdata;
    done_at = 0;
    mwe_cnt = 0;
    mwe_at  = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) bus.I_valid = 1'b0;
      bus.I_mstall = (cyc <= stall);
      #1;
      if (cyc == 1) begin
        check({tag, "_busy"}, {31'd0, bus.O_busy}, 32'd1);
        check({tag, "_done_c1"}, {31'd0, bus.O_done}, 32'd0);
        check({tag, "_mmask"}, {28'd0, bus.O_mmask}, {28'd0, exp_mask});
      end
      if (bus.O_mwe) begin
        mwe_cnt++;
        mwe_at = cyc;
        check({tag, "_maddr"}, bus.O_maddr, addr);
        check({tag, "_mdata"}, bus.O_mdata, wdata);
        check({tag, "_mask_at_we"}, {28'd0, bus.O_mmask}, {28'd0, exp_mask});
      end
      if (bus.O_done) begin
        done_at = cyc;
        break;
      end
    end
    bus.I_mstall = 1'b0;
    check({tag, "_latency"}, done_at, exp_lat);
    check({tag, "_mwe_count"}, mwe_cnt, (we && !exp_err) ? 1 : 0);
    if (we && !exp_err) check({tag, "_mwe_cycle"}, mwe_at, stall + 1);
    if (done_at != 0) begin
      check({tag, "_idle_at_done"}, {31'd0, bus.O_busy}, 32'd0);
      sb_pop(tag);
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  {31'd0, bus.O_busy}, 32'd0);
    check({tag, "_done"},  {31'd0, bus.O_done}, 32'd0);
    check({tag, "_err"},   {31'd0, bus.O_err},  32'd0);
    check({tag, "_mwe"},   {31'd0, bus.O_mwe},  32'd0);
    check({tag, "_mmask"}, {28'd0, bus.O_mmask}, 32'd0);
    check({tag, "_maddr"}, bus.O_maddr, 32'd0);
    check({tag, "_mdata"}, bus.O_mdata, 32'd0);
    check({tag, "_rdata"}, bus.O_rdata, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int seen_done;
    rst          = 1'b1;
    bus.I_valid  = 1'b0;
    bus.I_we     = 1'b0;
    bus.I_funct3 = 3'd0;
    bus.I_addr   = 32'd0;
    bus.I_wdata  = 32'd0;
    bus.I_mstall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    check("reset_state", {30'd0, bus.dbg_state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // Fill 0x100..0x103 with 44,33,22,11 and read it back.
    run_op("sw_fill", 1'b1, 3'd2, 32'h100, 32'h11223344, 0, 1'b0, 32'h00000000, 4'b1111, 3);
    run_op("lw_100",  1'b0, 3'd2, 32'h100, 32'h0,        0, 1'b0, 32'h11223344, 4'b0000, 3);
    // Byte extension on 0x80 at 0x101; upper store data bits are not written.
    run_op("sb_101",  1'b1, 3'd0, 32'h101, 32'hFFFFFF80, 0, 1'b0, 32'h11223344, 4'b0001, 3);
    run_op("lb_101",  1'b0, 3'd0, 32'h101, 32'h0,        0, 1'b0, 32'hFFFFFF80, 4'b0000, 3);
    run_op("lbu_101", 1'b0, 3'd4, 32'h101, 32'h0,        0, 1'b0, 32'h00000080, 4'b0000, 3);
    // Half word straddling the word boundary: 0x103 = 0x34, 0x104 = 0x92.
    run_op("sb_103",  1'b1, 3'd0, 32'h103, 32'h12345634, 0, 1'b0, 32'h00000080, 4'b0001, 3);
    run_op("sb_104",  1'b1, 3'd0, 32'h104, 32'h00000092, 0, 1'b0, 32'h00000080, 4'b0001, 3);
    run_op("lh_103",  1'b0, 3'd1, 32'h103, 32'h0,        0, 1'b0, 32'hFFFF9234, 4'b0000, 3);
    run_op("lhu_103", 1'b0, 3'd5, 32'h103, 32'h0,        0, 1'b0, 32'h00009234, 4'b0000, 3);
    // SH 0x102 then LW 0x100: bytes 44,80,EF,BE.
    run_op("sh_102",  1'b1, 3'd1, 32'h102, 32'hDEADBEEF, 0, 1'b0, 32'h00009234, 4'b0011, 3);
    run_op("lw_rb",   1'b0, 3'd2, 32'h100, 32'h0,        0, 1'b0, 32'hBEEF8044, 4'b0000, 3);
    // Stalled store: two stall cycles, write in the first unstalled cycle.
    run_op("sw_stall", 1'b1, 3'd2, 32'h200, 32'hCAFEF00D, 2, 1'b0, 32'hBEEF8044, 4'b1111, 5);
    run_op("lw_200",  1'b0, 3'd2, 32'h200, 32'h0,        0, 1'b0, 32'hCAFEF00D, 4'b0000, 3);
    run_op("lw_201",  1'b0, 3'd2, 32'h201, 32'h0,        0, 1'b0, 32'h00CAFEF0, 4'b0000, 3);
    run_op("lh_202",  1'b0, 3'd1, 32'h202, 32'h0,        0, 1'b0, 32'hFFFFCAFE, 4'b0000, 3);
    run_op("lbu_stall", 1'b0, 3'd4, 32'h203, 32'h0,      1, 1'b0, 32'h000000CA, 4'b0000, 4);
    // Illegal encodings: no access, O_rdata unchanged.
    run_op("ld_f3_3", 1'b0, 3'd3, 32'h100, 32'h0,        0, 1'b1, 32'h000000CA, 4'b0000, 2);
    run_op("st_f3_5", 1'b1, 3'd5, 32'h100, 32'h01020304, 0, 1'b1, 32'h000000CA, 4'b0000, 2);
    run_op("ld_f3_7", 1'b0, 3'd7, 32'h100, 32'h0,        0, 1'b1, 32'h000000CA, 4'b0000, 2);
    run_op("lw_after_err", 1'b0, 3'd2, 32'h100, 32'h0,   0, 1'b0, 32'hBEEF8044, 4'b0000, 3);

    // Reset in WAIT of an LW: no O_done, everything zero afterwards.
    bus.I_valid  = 1'b1;
    bus.I_we     = 1'b0;
    bus.I_funct3 = 3'd2;
    bus.I_addr   = 32'h100;
    @(negedge clk);
    bus.I_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_wait_state", {30'd0, bus.dbg_state}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_wait");
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (bus.O_done) seen_done++;
    end
    check("rst_wait_no_done", seen_done, 0);

    // Reset in ISSUE of a store: no write in the reset cycle.
    bus.I_valid  = 1'b1;
    bus.I_we     = 1'b1;
    bus.I_funct3 = 3'd0;
    bus.I_addr   = 32'h100;
    bus.I_wdata  = 32'h00000055;
    @(negedge clk);
    bus.I_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_issue_mwe", {31'd0, bus.O_mwe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("rst_issue");
    run_op("lw_after_rst", 1'b0, 3'd2, 32'h100, 32'h0, 0, 1'b0, 32'hBEEF8044, 4'b0000, 3);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_port.md
# lsu_port

Load/store initiator between the RISC-V core's execute stage and the byte-banked data memory port (address, data, byte mask, write enable in; registered read data and stall out). It accepts one load or store per request, drives the memory port, then returns a completed result to the core. For loads it undoes the memory's bank-order byte layout and sign- or zero-extends the result per funct3. It also rejects encodings that are not legal loads or stores.

## Interface
- No parameters.
- I_clk  in  1  clock, rising edge
- I_rst  in  1  reset, synchronous, active-high
- I_valid  in  1  core request strobe; sampled only in IDLE
- I_we  in  1  1 = store, 0 = load
- I_funct3  in  3  RV32I width/sign code (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2)
- I_addr  in  32  byte address; any alignment
- I_wdata  in  32  store data (rs2), used from the low byte up
- O_busy  out  1  request in flight (state ≠ IDLE)
- O_done  out  1  one-cycle completion pulse
- O_err  out  1  with O_done: illegal funct3; no memory access made
- O_rdata  out  32  extended load result; holds until the next completed load
- O_maddr  out  32  memory address
- O_mdata  out  32  memory write data
- O_mmask  out  4  memory byte-lane mask
- O_mwe  out  1  memory write enable
- I_mdata  in  32  memory read data; registered, bank order {b3,b2,b1,b0}
- I_mstall  in  1  memory not ready

## Operation
- States:
  - IDLE: on I_valid, latch we/funct3/addr/wdata.
    - Legal request → ISSUE.
    - Illegal request → ERR.
  - ISSUE: if I_mstall, stay in ISSUE with O_mwe = 0. Otherwise drive the access and go to WAIT.
  - WAIT: capture the result and go to IDLE.
  - ERR: go to IDLE.
- Legal funct3:
  - Loads: 0, 1, 2, 4, 5.
  - Stores: 0, 1, 2.
  - Anything else is illegal.
- Port driving:
  - O_maddr = latched address, held from ISSUE until the next acceptance.
  - O_mdata = latched wdata, unmodified. The memory performs lane rotation itself.
  - O_mmask in ISSUE:
    - SB: 0001
    - SH: 0011
    - SW: 1111
    - Loads: 0000
  - O_mmask = 0000 in all other states.
  - O_mwe = 1 only in an ISSUE cycle that is a store with I_mstall = 0. It is therefore exactly one cycle per store.
- Load result: rot = I_mdata rotated right by 8×addr[1:0]. Then:
  - LB: sext(rot[7:0])
  - LH: sext(rot[15:0])
  - LW: rot
  - LBU: zext(rot[7:0])
  - LHU: zext(rot[15:0])
- Stores and ERR leave O_rdata unchanged.
- O_done is set by the edge leaving WAIT or ERR. O_err is set only by the edge leaving ERR.
- I_valid while O_busy = 1 is ignored. The core holds the request until it sees O_done.

## Timing
- Reset values: state IDLE; O_busy, O_done, O_err, O_mwe, O_mmask, O_maddr, O_mdata, O_rdata all 0.
- Reset mid-operation: a reset in any state aborts the request. No O_done is produced, and no write occurs in the reset cycle.
- Legal request, no stall: I_valid sampled at edge of cycle n.
  - ISSUE in n+1.
  - WAIT in n+2, with I_mdata valid.
  - O_done = 1 and O_rdata valid in n+3.
- Each stall cycle in ISSUE adds one cycle of latency. I_mstall is ignored in WAIT.
- Illegal request: O_done = O_err = 1 in n+2. O_mwe and O_mmask stay 0 throughout.
- The O_done cycle is an IDLE cycle. A new I_valid in that cycle is accepted, giving back-to-back throughput of one access per 3 cycles.
- No combinational path from I_valid or I_mdata to any memory-port output.

## Test plan
- LW aligned: memory bytes 0x100..0x103 = 44,33,22,11; LW 0x100 → O_rdata 0x11223344, O_done exactly 3 cycles after I_valid, O_mwe never high.
- Byte extension: byte 0x80 at 0x101 → LB 0x101 gives 0xFFFFFF80; LBU 0x101 gives 0x00000080.
- Unaligned half: 0x103 = 0x34, 0x104 = 0x92 → LH 0x103 gives 0xFFFF9234; LHU 0x103 gives 0x00009234.
- Store then readback: SH 0x102 with wdata 0xDEADBEEF → one cycle of O_mwe = 1, O_mmask = 0011, O_mdata = 0xDEADBEEF, O_maddr = 0x102. Then LW 0x100 returns 0xBEEFxxxx with the low half preserved.
- Stall: I_mstall high for 2 cycles in ISSUE of SW 0x200 → O_mwe low during stall and high in the first unstalled cycle only; O_done 5 cycles after I_valid.
- Error and reset:
  - Load with funct3 = 3 → O_done = O_err = 1 two cycles after I_valid, no O_mwe, O_rdata unchanged.
  - I_rst asserted in WAIT of an LW → no O_done; all outputs 0 on the next cycle.
